// File: rtl/lane_distributor_pkg.sv
// Shared types and sizing helpers for the PCS transmit lane distributor.
package pcs_dist_pkg;

   typedef enum logic [1:0] {
      NORMAL     = 2'b00,
      WAIT4CLEAN = 2'b01,
      WAIT4IDLE  = 2'b10
   } dist_state_e;

   // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int SYNC_COUNT_W = 16;

endpackage

// File: rtl/lane_distributor_timer.sv
// Sync-period counter: wraps every SYNC_PERIOD NORMAL cycles, flags skip
// slots and the cnt==0 alignment trigger, reloads to 1 on a forced sync.
module lane_dist_timer
   import pcs_dist_pkg::*;
#(
   parameter int SYNC_PERIOD   = 1024,
   parameter int SKIP_INTERVAL = 384,
   parameter int CNT_W         = cnt_width(SYNC_PERIOD)
) (
   input  logic clk,
   input  logic reset,
   input  logic advance,
   input  logic force_load,
   output logic skip,
   output logic cnt_zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // SYNC_PERIOD is a power of two, so the natural binary wrap is the modulo.
   always_comb begin
      cnt_d = cnt_q;
      if (advance) begin
         cnt_d = force_load ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end
   end

   // Counter register; returns to the sync point on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_zero = (cnt_q == '0);
   assign skip     = !cnt_zero && ((32'(cnt_q) % SKIP_INTERVAL) == 0);

endmodule

// File: rtl/lane_distributor.sv
// Transmit lane distributor: passes the swizzled word to the per-lane
// encoders, gates lane enables on readiness, inserts skip slots and
// alignment sync cycles, and watches for syncs that never complete.
module lane_distributor
   import pcs_dist_pkg::*;
#(
   parameter int LANES         = 4,
   parameter int UNIT_W        = 66,
   parameter int SYNC_PERIOD   = 1024,
   parameter int SKIP_INTERVAL = 384,
   parameter int IDLE_TIMEOUT  = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_enable,
   input  logic [LANES*UNIT_W-1:0]   in_txdata,
   input  logic                      in_txdata_en,
   output logic                      out_ready,
   output logic                      out_syncing_pre,
   input  logic                      in_empty,
   input  logic                      in_force_sync,
   input  logic [LANES-1:0]          in_lane_mask,
   input  logic [LANES-1:0]          in_lane_ready,
   output logic [LANES*UNIT_W-1:0]   out_txdata,
   output logic [LANES-1:0]          out_txdata_en,
   output logic [LANES-1:0]          out_txsync,
   output logic                      out_sync_timeout,
   output logic [SYNC_COUNT_W-1:0]   out_sync_count
);

   localparam int TCNT_W = cnt_width(IDLE_TIMEOUT);

   dist_state_e             state_q, state_d;
   logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
   logic                    timeout_q, timeout_d;
   logic [SYNC_COUNT_W-1:0] count_q, count_d;

   logic active;
   logic allready;
   logic skip;
   logic cnt_zero;
   logic sync_fire;
   logic timer_advance;

   // Outputs stay quiet while held in reset or paused.
   assign active        = in_enable & ~reset;
   assign allready      = &(in_lane_ready | ~in_lane_mask);
   assign timer_advance = active && (state_q == NORMAL);

   lane_dist_timer #(
      .SYNC_PERIOD   (SYNC_PERIOD),
      .SKIP_INTERVAL (SKIP_INTERVAL)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .advance    (timer_advance),
      .force_load (timer_advance & in_force_sync),
      .skip       (skip),
      .cnt_zero   (cnt_zero)
   );

   // Next-state, watchdog and handshake decode for the sync FSM.
   always_comb begin
      state_d         = state_q;
      tcnt_d          = tcnt_q;
      timeout_d       = timeout_q;
      count_d         = count_q;
      out_ready       = 1'b0;
      out_syncing_pre = 1'b0;
      sync_fire       = 1'b0;
      if (active) begin
         unique case (state_q)
            NORMAL: begin
               out_ready = allready & ~skip;
               if (cnt_zero || in_force_sync) begin
                  if (in_empty) begin
                     state_d = WAIT4IDLE;
                  end else begin
                     state_d         = WAIT4CLEAN;
                     out_syncing_pre = 1'b1;
                  end
               end
            end
            WAIT4CLEAN: begin
               if (in_empty) begin
                  state_d = WAIT4IDLE;
               end else begin
                  out_syncing_pre = 1'b1;
                  out_ready       = allready;
               end
            end
            WAIT4IDLE: begin
               tcnt_d = tcnt_q + TCNT_W'(1);
               if (allready) begin
                  sync_fire = 1'b1;
                  count_d   = count_q + SYNC_COUNT_W'(1);
                  tcnt_d    = '0;
                  state_d   = NORMAL;
               end else if (tcnt_q == TCNT_W'(IDLE_TIMEOUT - 1)) begin
                  timeout_d = 1'b1;
                  tcnt_d    = '0;
                  state_d   = NORMAL;
               end
            end
            default: begin
               state_d = NORMAL;
            end
         endcase
      end
   end

   // Control registers; reset lands in NORMAL so a fresh sync follows.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= NORMAL;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   // Per-lane gating: masked lanes never see an enable or a sync strobe.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign out_txdata_en[i] = in_lane_mask[i] & (sync_fire | (in_txdata_en & out_ready));
      assign out_txsync[i]    = in_lane_mask[i] & sync_fire;
   end

   assign out_txdata       = in_txdata;
   assign out_sync_timeout = timeout_q;
   assign out_sync_count   = count_q;

endmodule

// File: tb/tb_lane_distributor.sv
// Self-checking bench for lane_distributor: a cycle model pushes expected
// outputs into a scoreboard queue, which is popped against the DUT mid-cycle.
module tb_lane_distributor;

   localparam int LN = 4;
   localparam int UW = 66;
   localparam int SP = 64;
   localparam int SI = 24;
   localparam int IT = 8;
   localparam int DW = LN * UW;

   localparam int S_NORMAL = 0;
   localparam int S_CLEAN  = 1;
   localparam int S_IDLE   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_enable;
   logic [DW-1:0] in_txdata;
   logic          in_txdata_en;
   logic          out_ready;
   logic          out_syncing_pre;
   logic          in_empty;
   logic          in_force_sync;
   logic [LN-1:0] in_lane_mask;
   logic [LN-1:0] in_lane_ready;
   logic [DW-1:0] out_txdata;
   logic [LN-1:0] out_txdata_en;
   logic [LN-1:0] out_txsync;
   logic          out_sync_timeout;
   logic [15:0]   out_sync_count;

   lane_distributor #(
      .LANES         (LN),
      .UNIT_W        (UW),
      .SYNC_PERIOD   (SP),
      .SKIP_INTERVAL (SI),
      .IDLE_TIMEOUT  (IT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_enable        (in_enable),
      .in_txdata        (in_txdata),
      .in_txdata_en     (in_txdata_en),
      .out_ready        (out_ready),
      .out_syncing_pre  (out_syncing_pre),
      .in_empty         (in_empty),
      .in_force_sync    (in_force_sync),
      .in_lane_mask     (in_lane_mask),
      .in_lane_ready    (in_lane_ready),
      .out_txdata       (out_txdata),
      .out_txdata_en    (out_txdata_en),
      .out_txsync       (out_txsync),
      .out_sync_timeout (out_sync_timeout),
      .out_sync_count   (out_sync_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ready;
      logic          pre;
      logic [LN-1:0] en;
      logic [LN-1:0] sync;
      logic          to;
      logic [15:0]   sc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state (registered) and its next values.
   int          m_state, m_cnt, m_tcnt;
   logic        m_to;
   logic [15:0] m_sc;
   int          n_state, n_cnt, n_tcnt;
   logic        n_to;
   logic [15:0] n_sc;

   // Observations of the last sampled cycle and per-scenario accumulators.
   logic          obs_ready, obs_pre;
   logic [LN-1:0] obs_en, obs_sync;
   int            low_cnt, pre_cnt;
   logic [LN-1:0] or_en, or_sync;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      exp_t e;
      logic allr, skp, fire;
      allr = &(in_lane_ready | ~in_lane_mask);
      skp  = (m_cnt != 0) && ((m_cnt % SI) == 0);
      fire = 1'b0;
      e.ready = 1'b0;
      e.pre   = 1'b0;
      e.to    = m_to;
      e.sc    = m_sc;
      e.data  = in_txdata;
      n_state = m_state; n_cnt = m_cnt; n_tcnt = m_tcnt; n_to = m_to; n_sc = m_sc;
      if (reset) begin
         n_state = S_NORMAL; n_cnt = 0; n_tcnt = 0; n_to = 1'b0; n_sc = '0;
      end else if (in_enable) begin
         if (m_state == S_NORMAL) begin
            e.ready = allr && !skp;
            n_cnt   = in_force_sync ? 1 : (m_cnt + 1) % SP;
            if (m_cnt == 0 || in_force_sync) begin
               if (in_empty) n_state = S_IDLE;
               else begin
                  n_state = S_CLEAN;
                  e.pre   = 1'b1;
               end
            end
         end else if (m_state == S_CLEAN) begin
            if (in_empty) n_state = S_IDLE;
            else begin
               e.pre   = 1'b1;
               e.ready = allr;
            end
         end else begin
            if (allr) begin
               fire    = 1'b1;
               n_sc    = m_sc + 16'd1;
               n_tcnt  = 0;
               n_state = S_NORMAL;
            end else if (m_tcnt == IT - 1) begin
               n_to    = 1'b1;
               n_tcnt  = 0;
               n_state = S_NORMAL;
            end else begin
               n_tcnt  = m_tcnt + 1;
            end
         end
      end
      e.sync = fire ? in_lane_mask : '0;
      e.en   = (fire || (in_txdata_en && e.ready)) ? in_lane_mask : '0;
      sb.push_back(e);
   endtask

   // One clock: fresh data, model, compare mid-cycle, then advance the model.
   task automatic cycle();
      exp_t e;
      logic [287:0] r;
      for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
      in_txdata = r[DW-1:0];
      model_eval();
      #3;
      e = sb.pop_front();
      chk("ready",   DW'(out_ready),        DW'(e.ready));
      chk("pre",     DW'(out_syncing_pre),  DW'(e.pre));
      chk("en",      DW'(out_txdata_en),    DW'(e.en));
      chk("sync",    DW'(out_txsync),       DW'(e.sync));
      chk("timeout", DW'(out_sync_timeout), DW'(e.to));
      chk("count",   DW'(out_sync_count),   DW'(e.sc));
      chk("data",    out_txdata,            e.data);
      chk("inv_en",  DW'(out_txdata_en & ~(in_lane_ready & in_lane_mask)), '0);
      chk("inv_rdy", DW'(out_ready & ~(&(in_lane_ready | ~in_lane_mask))), '0);
      obs_ready = out_ready;
      obs_pre   = out_syncing_pre;
      obs_en    = out_txdata_en;
      obs_sync  = out_txsync;
      if (!out_ready) low_cnt++;
      if (out_syncing_pre) pre_cnt++;
      or_en   |= out_txdata_en;
      or_sync |= out_txsync;
      @(posedge clk);
      #1;
      m_state = n_state; m_cnt = n_cnt; m_tcnt = n_tcnt; m_to = n_to; m_sc = n_sc;
   endtask

   task automatic clear_acc();
      low_cnt = 0; pre_cnt = 0; or_en = '0; or_sync = '0;
   endtask

   task automatic run_until(input int st, input int cn, input int lim);
      int k = 0;
      while (!(m_state == st && m_cnt == cn) && k < lim) begin
         cycle();
         k++;
      end
      chk("reach_bound", DW'(k < lim || (m_state == st && m_cnt == cn)), DW'(1));
   endtask

   initial begin
      m_state = S_NORMAL; m_cnt = 0; m_tcnt = 0; m_to = 1'b0; m_sc = '0;
      reset = 1'b1; in_enable = 1'b1; in_txdata = '0; in_txdata_en = 1'b1;
      in_empty = 1'b1; in_force_sync = 1'b0; in_lane_mask = 4'hF; in_lane_ready = 4'hF;
      clear_acc();
      @(posedge clk);
      #1;

      // Reset held: everything quiet; then the first alignment sync.
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      cycle();
      chk("first_sync", DW'(obs_sync), DW'(4'hF));
      chk("first_en",   DW'(obs_en),   DW'(4'hF));
      chk("count_1",    DW'(out_sync_count), DW'(1));

      // Steady traffic: skip slots at cnt 24 and 48, next sync on wrap.
      clear_acc();
      run_until(S_NORMAL, 0, 200);
      chk("skip_lows", DW'(low_cnt), DW'(2));
      cycle();
      cycle();
      chk("count_2", DW'(out_sync_count), DW'(2));

      // Swizzler not empty at trigger: drain with syncing_pre, dead cycle, sync.
      run_until(S_NORMAL, 0, 200);
      clear_acc();
      in_empty = 1'b0;
      repeat (4) cycle();
      in_empty = 1'b1;
      cycle();
      chk("dead_cycle", DW'(obs_ready), DW'(0));
      cycle();
      chk("pre_cycles", DW'(pre_cnt), DW'(4));
      chk("drain_sync", DW'(obs_sync), DW'(4'hF));

      // Partial mask with lanes 1 and 3 never ready.
      in_lane_mask = 4'b0101; in_lane_ready = 4'b0101;
      clear_acc();
      run_until(S_NORMAL, 0, 200);
      cycle();
      cycle();
      chk("mask_sync",   DW'(obs_sync), DW'(4'b0101));
      chk("masked_lane", DW'(or_en & 4'b1010), DW'(0));
      chk("count_4",     DW'(out_sync_count), DW'(4));

      // Lane 2 stuck in WAIT4IDLE: watchdog aborts, flag sticks.
      in_lane_mask = 4'hF; in_lane_ready = 4'hF;
      run_until(S_NORMAL, 0, 200);
      in_lane_ready = 4'b1011;
      clear_acc();
      repeat (9) cycle();
      chk("timeout_set", DW'(out_sync_timeout), DW'(1));
      chk("no_sync",     DW'(or_sync), DW'(0));
      in_lane_ready = 4'hF;
      repeat (5) cycle();
      chk("timeout_sticky", DW'(out_sync_timeout), DW'(1));
      chk("count_held",     DW'(out_sync_count), DW'(4));

      // Forced sync at cnt 10, then an in_enable pause.
      run_until(S_NORMAL, 10, 200);
      in_force_sync = 1'b1;
      cycle();
      in_force_sync = 1'b0;
      cycle();
      chk("force_sync", DW'(obs_sync), DW'(4'hF));
      chk("count_5",    DW'(out_sync_count), DW'(5));
      in_enable = 1'b0;
      clear_acc();
      repeat (3) cycle();
      chk("pause_en", DW'(or_en), DW'(0));
      in_enable = 1'b1;
      run_until(S_NORMAL, 25, 200);

      // Reset in the middle of a drain: back to NORMAL, fresh sync.
      run_until(S_NORMAL, 0, 200);
      in_empty = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      chk("reset_clr_to", DW'(out_sync_timeout), DW'(0));
      reset = 1'b0; in_empty = 1'b1;
      cycle();
      cycle();
      chk("reset_sync", DW'(obs_sync), DW'(4'hF));
      chk("count_rst",  DW'(out_sync_count), DW'(1));

      // Random mix of all inputs against the model.
      for (int n = 0; n < 600; n++) begin
         reset         = ($urandom_range(0, 199) == 0);
         in_enable     = ($urandom_range(0, 9) != 0);
         in_txdata_en  = ($urandom_range(0, 3) != 0);
         in_empty      = ($urandom_range(0, 9) < 7);
         in_force_sync = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0) in_lane_mask = 4'($urandom);
         in_lane_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
